// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter whose bits update through JK toggle cells.
// Define JK_CNT_SATURATE_EN to saturate at the limits instead of wrapping (wrap tied low).
module jk_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] jv,
    output logic [WIDTH-1:0] kv,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   din_ext;
    logic [WIDTH:0]   nxt_ext;
    logic [WIDTH-1:0] nxt;

    assign q_ext   = {1'b0, q};
    assign din_ext = {1'b0, din};

    always_comb begin
        nxt_ext = q_ext;
        if (load) begin
            nxt_ext = (din_ext > MAX) ? MAX : din_ext;
        end else if (en) begin
            // an upset value beyond the legal range recovers to 0 in either direction
            if (q_ext > MAX) begin
                nxt_ext = '0;
            end else if (up) begin
                if (q_ext == MAX) begin
`ifdef JK_CNT_SATURATE_EN
                    nxt_ext = MAX;
`else
                    nxt_ext = '0;
`endif
                end else begin
                    nxt_ext = q_ext + (WIDTH+1)'(1);
                end
            end else begin
                if (q_ext == '0) begin
`ifdef JK_CNT_SATURATE_EN
                    nxt_ext = '0;
`else
                    nxt_ext = MAX;
`endif
                end else begin
                    nxt_ext = q_ext - (WIDTH+1)'(1);
                end
            end
        end
        nxt = nxt_ext[WIDTH-1:0];
    end

    // J only where a bit rises, K only where it falls, so J&K never coincide
    assign jv = ~q & nxt;
    assign kv = q & ~nxt;

    assign tc = en & ~load & (up ? (q_ext == MAX) : (q_ext == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                case ({jv[i], kv[i]})
                    2'b10:   q[i] <= 1'b1;
                    2'b01:   q[i] <= 1'b0;
                    2'b11:   q[i] <= ~q[i];
                    default: q[i] <= q[i];
                endcase
            end
`ifdef JK_CNT_SATURATE_EN
            wrap <= 1'b0;
`else
            wrap <= tc;
`endif
        end
    end

endmodule
